game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller for the pitch game. It sequences play through idle, countdown, run, hit and game-over phases, and owns the pipe datapath state: horizontal position, gap placement and respawn. It also keeps the score and high score. It sits between the game-tick clock divider, the collision detector and the VGA colour mux: it consumes the slow tick pulse, the start button and `collided`, and drives the pipe coordinates and status outputs.

## Interface
- `SCREEN_W`, 640, visible width in pixels
- `PIPE_W`, 50, pipe half-width; respawn x = `SCREEN_W + PIPE_W`
- `BIRD_X`, 100, bird centre x used for scoring
- `SPEED`, 4, pixels the pipe moves per tick
- `GAP_MIN`, 60, minimum `pipe_y_top`
- `GAP_H`, 160, vertical gap height (`pipe_y_bot - pipe_y_top`)
- `READY_TICKS`, 3, countdown length in ticks (1..15)
- `DEAD_TICKS`, 4, hit-flash length in ticks (1..15)
- `clk` in 1: system clock, single clock domain
- `reset` in 1: synchronous, active-high
- `tick` in 1: one-`clk`-cycle game-tick enable pulse
- `start_button` in 1: active-high level, already inverted and synchronised
- `collided` in 1: level from the collision block
- `state` out 3: IDLE=0, COUNTDOWN=1, RUN=2, HIT=3, OVER=4
- `pipe_x` out 10: pipe centre x
- `pipe_y_top`, `pipe_y_bot` out 10 each: gap bounds
- `score`, `hi_score` out 8 each: binary score values
- `countdown` out 4: remaining countdown ticks
- `spawn` out 1: one-cycle pulse on pipe respawn
- `flash` out 1: blink during HIT
- `game_over` out 1: high in OVER

## Operation
- **Start edge.** `start_q` is a registered copy of `start_button`. `start_edge = start_button & ~start_q`. Holding the button never retriggers.
- **LFSR.** 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Seeded 8'hA5 on reset. Advances every `clk`.
- **New gap.** `pipe_y_top = GAP_MIN + lfsr`, `pipe_y_bot = pipe_y_top + GAP_H`. Maximum bottom is 60+255+160 = 475 < 480.
- **IDLE.** Outputs hold reset values. `start_edge` → COUNTDOWN.
- **COUNTDOWN.** On entry: `countdown = READY_TICKS`, `score = 0`, `pipe_x = SCREEN_W + PIPE_W`, new gap loaded.
  - Each `tick` decrements `countdown`.
  - The tick that takes it to 0 → RUN.
  - `collided` is ignored in this state.
- **RUN.** `collided` high on any cycle → HIT. Collision has priority over a same-cycle `tick`: no move, no score that cycle.
- **RUN, `tick` without collision, `pipe_x < SPEED`.** `pipe_x = SCREEN_W + PIPE_W`, new gap loaded, `spawn = 1` for one cycle.
- **RUN, `tick` without collision, otherwise.** `pipe_x -= SPEED`.
  - If the old `pipe_x >= BIRD_X` and the new `pipe_x < BIRD_X`, `score` increments.
  - `score` saturates at 255.
- **HIT.** Pipe and score are frozen. `flash` toggles on each `tick`. After `DEAD_TICKS` ticks → OVER, with `flash = 0`.
- **OVER.**
  - On entry: if `score > hi_score`, `hi_score = score`.
  - `game_over = 1`; `score` and pipe state are held.
  - `start_edge` → COUNTDOWN.
- **Illegal state encodings** → IDLE on the next `clk`.

## Timing
- All outputs are registered. An input event on cycle n is visible on outputs at n+1.
- **Reset values:**
  - `state` = IDLE
  - `pipe_x` = 690
  - `pipe_y_top` = 200, `pipe_y_bot` = 360
  - `score` = 0, `hi_score` = 0
  - `countdown` = 0
  - `spawn` = 0, `flash` = 0, `game_over` = 0
  - `start_q` = 0, `lfsr` = 8'hA5
- Reset at any time, including mid-RUN or mid-HIT, restores all reset values on the next edge. `hi_score` is cleared too.
- `tick` high for more than one cycle counts once per cycle. Ticks outside COUNTDOWN, RUN and HIT are ignored.
- `spawn` and the new gap update on the same edge. `spawn` is never high outside RUN.
- `start_edge` in COUNTDOWN, RUN or HIT is ignored.
- A `start_edge` on the same cycle as the OVER entry is ignored; it needs a new press.

## Test plan
Defaults for all scenarios except where overridden: SPEED=4, READY_TICKS=3, DEAD_TICKS=4.
- **Reset/idle.** Reset 2 cycles, then 10 ticks with no start → all outputs at reset values, `state` = 0.
- **Countdown.** Start pulse, then ticks:
  - `countdown` steps 3→2→1.
  - `state` = RUN one cycle after the 3rd tick.
  - Holding the button for 20 cycles causes no retrigger.
- **Scoring and wrap.** In RUN with no collision:
  - After 147 ticks: `pipe_x` = 102, `score` = 0.
  - Tick 148: `pipe_x` = 98, `score` = 1.
  - Tick 172: `pipe_x` = 2.
  - Tick 173: `pipe_x` = 690, one-cycle `spawn`, `pipe_y_top` in 60..315, `pipe_y_bot = pipe_y_top + 160`.
- **Collision priority.** `collided` and `tick` in the same RUN cycle:
  - `pipe_x` and `score` unchanged, `state` = HIT next cycle.
  - `flash` toggles on each of 4 ticks, then `state` = OVER with `game_over` = 1.
- **High score and restart.**
  - Game ending with score 1 → `hi_score` = 1.
  - Start edge → COUNTDOWN, `score` = 0, `pipe_x` = 690.
  - Next game ending with score 0 → `hi_score` stays 1.
- **Mid-operation reset.** Assert reset during HIT with `hi_score` = 1 → next cycle all outputs are at reset values, including `hi_score` = 0.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: phase controller for the pitch game. Owns the pipe position,
// gap placement, respawn, score and high score. All outputs are registered.
module game_sequencer #(
  parameter int SCREEN_W    = 640,
  parameter int PIPE_W      = 50,
  parameter int BIRD_X      = 100,
  parameter int SPEED       = 4,
  parameter int GAP_MIN     = 60,
  parameter int GAP_H       = 160,
  parameter int READY_TICKS = 3,
  parameter int DEAD_TICKS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_button,
  input  logic       collided,
  output logic [2:0] state,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y_top,
  output logic [9:0] pipe_y_bot,
  output logic [7:0] score,
  output logic [7:0] hi_score,
  output logic [3:0] countdown,
  output logic       spawn,
  output logic       flash,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_HIT       = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  localparam logic [9:0] RESPAWN_X = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] SPEED_X   = 10'(SPEED);
  localparam logic [9:0] BIRD_XX   = 10'(BIRD_X);
  localparam logic [9:0] GAP_MIN_X = 10'(GAP_MIN);
  localparam logic [9:0] GAP_H_X   = 10'(GAP_H);
  localparam logic [3:0] READY_N   = 4'(READY_TICKS);
  localparam logic [3:0] DEAD_LAST = 4'(DEAD_TICKS - 1);

  state_t     state_q, state_d;
  logic [9:0] pipe_x_q, pipe_x_d;
  logic [9:0] top_q, top_d;
  logic [9:0] bot_q, bot_d;
  logic [7:0] score_q, score_d;
  logic [7:0] hi_q, hi_d;
  logic [3:0] countdown_q, countdown_d;
  logic [3:0] dead_q, dead_d;
  logic       spawn_q, spawn_d;
  logic       flash_q, flash_d;
  logic       over_q, over_d;
  logic       start_q, start_d;
  logic [7:0] lfsr_q, lfsr_d;

  logic       start_edge;
  logic       load_round;
  logic       new_gap;
  logic [9:0] moved_x;

  assign start_edge = start_button & ~start_q;
  assign moved_x    = pipe_x_q - SPEED_X;

  // Next-state logic: phase sequencing plus pipe/score datapath updates.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    pipe_x_d    = pipe_x_q;
    top_d       = top_q;
    bot_d       = bot_q;
    score_d     = score_q;
    hi_d        = hi_q;
    countdown_d = countdown_q;
    dead_d      = dead_q;
    spawn_d     = 1'b0;
    flash_d     = flash_q;
    start_d     = start_button;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    load_round  = 1'b0;
    new_gap     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) load_round = 1'b1;
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (countdown_q <= 4'd1) begin
            countdown_d = 4'd0;
            state_d     = S_RUN;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end
      end
      S_RUN: begin
        // Collision wins over a same-cycle tick: nothing moves or scores.
        if (collided) begin
          state_d = S_HIT;
          dead_d  = 4'd0;
          flash_d = 1'b0;
        end else if (tick) begin
          if (pipe_x_q < SPEED_X) begin
            pipe_x_d = RESPAWN_X;
            new_gap  = 1'b1;
            spawn_d  = 1'b1;
          end else begin
            pipe_x_d = moved_x;
            if (pipe_x_q >= BIRD_XX && moved_x < BIRD_XX && score_q != 8'hFF)
              score_d = score_q + 8'd1;
          end
        end
      end
      S_HIT: begin
        if (tick) begin
          if (dead_q == DEAD_LAST) begin
            state_d = S_OVER;
            flash_d = 1'b0;
            if (score_q > hi_q) hi_d = score_q;
          end else begin
            dead_d  = dead_q + 4'd1;
            flash_d = ~flash_q;
          end
        end
      end
      S_OVER: begin
        if (start_edge) load_round = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_round) begin
      state_d     = S_COUNTDOWN;
      countdown_d = READY_N;
      score_d     = 8'd0;
      pipe_x_d    = RESPAWN_X;
      new_gap     = 1'b1;
    end

    if (new_gap) begin
      top_d = GAP_MIN_X + {2'b00, lfsr_q};
      bot_d = GAP_MIN_X + {2'b00, lfsr_q} + GAP_H_X;
    end

    over_d = (state_d == S_OVER);
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pipe_x_q    <= RESPAWN_X;
      top_q       <= 10'd200;
      bot_q       <= 10'd360;
      score_q     <= 8'd0;
      hi_q        <= 8'd0;
      countdown_q <= 4'd0;
      dead_q      <= 4'd0;
      spawn_q     <= 1'b0;
      flash_q     <= 1'b0;
      over_q      <= 1'b0;
      start_q     <= 1'b0;
      lfsr_q      <= 8'hA5;
    end else begin
      state_q     <= state_d;
      pipe_x_q    <= pipe_x_d;
      top_q       <= top_d;
      bot_q       <= bot_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      countdown_q <= countdown_d;
      dead_q      <= dead_d;
      spawn_q     <= spawn_d;
      flash_q     <= flash_d;
      over_q      <= over_d;
      start_q     <= start_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign state      = state_q;
  assign pipe_x     = pipe_x_q;
  assign pipe_y_top = top_q;
  assign pipe_y_bot = bot_q;
  assign score      = score_q;
  assign hi_score   = hi_q;
  assign countdown  = countdown_q;
  assign spawn      = spawn_q;
  assign flash      = flash_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of game_sequencer phases, scoring,
// respawn, collision priority, high score and mid-game reset.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_button = 1'b0;
  logic       collided = 1'b0;
  logic [2:0] state;
  logic [9:0] pipe_x, pipe_y_top, pipe_y_bot;
  logic [7:0] score, hi_score;
  logic [3:0] countdown;
  logic       spawn, flash, game_over;

  int n_checks = 0;
  int n_fail   = 0;

  game_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_button (start_button),
    .collided     (collided),
    .state        (state),
    .pipe_x       (pipe_x),
    .pipe_y_top   (pipe_y_top),
    .pipe_y_bot   (pipe_y_bot),
    .score        (score),
    .hi_score     (hi_score),
    .countdown    (countdown),
    .spawn        (spawn),
    .flash        (flash),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse_tick();
  endtask

  task automatic pulse_start();
    start_button = 1'b1;
    cyc(1);
    start_button = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_state"},   32'(state),      32'd0);
    check({p, "_pipe_x"},  32'(pipe_x),     32'd690);
    check({p, "_top"},     32'(pipe_y_top), 32'd200);
    check({p, "_bot"},     32'(pipe_y_bot), 32'd360);
    check({p, "_score"},   32'(score),      32'd0);
    check({p, "_hi"},      32'(hi_score),   32'd0);
    check({p, "_cdown"},   32'(countdown),  32'd0);
    check({p, "_spawn"},   32'(spawn),      32'd0);
    check({p, "_flash"},   32'(flash),      32'd0);
    check({p, "_over"},    32'(game_over),  32'd0);
  endtask

  task automatic check_gap(input string p);
    check({p, "_top_range"}, 32'(pipe_y_top >= 10'd60 && pipe_y_top <= 10'd315), 32'd1);
    check({p, "_bot_gap"},   32'(pipe_y_bot), 32'(pipe_y_top) + 32'd160);
  endtask

  initial begin
    // Reset / idle
    cyc(1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check_reset_vals("rst");
    ticks(10);
    check_reset_vals("idle");

    // Countdown with the button held throughout
    start_button = 1'b1;
    cyc(1);
    check("cd_state", 32'(state), 32'd1);
    check("cd_val3", 32'(countdown), 32'd3);
    check("cd_score", 32'(score), 32'd0);
    check("cd_pipe_x", 32'(pipe_x), 32'd690);
    check_gap("cd");
    cyc(20);
    check("hold_state", 32'(state), 32'd1);
    check("hold_cd", 32'(countdown), 32'd3);
    pulse_tick();
    check("cd_val2", 32'(countdown), 32'd2);
    pulse_tick();
    check("cd_val1", 32'(countdown), 32'd1);
    check("cd_still", 32'(state), 32'd1);
    pulse_tick();
    check("run_state", 32'(state), 32'd2);
    check("run_cd0", 32'(countdown), 32'd0);
    start_button = 1'b0;
    cyc(1);

    // Scoring and wrap
    ticks(147);
    check("x_147", 32'(pipe_x), 32'd102);
    check("score_147", 32'(score), 32'd0);
    pulse_tick();
    check("x_148", 32'(pipe_x), 32'd98);
    check("score_148", 32'(score), 32'd1);
    ticks(24);
    check("x_172", 32'(pipe_x), 32'd2);
    check("spawn_172", 32'(spawn), 32'd0);
    pulse_tick();
    check("x_173", 32'(pipe_x), 32'd690);
    check("spawn_173", 32'(spawn), 32'd1);
    check("score_173", 32'(score), 32'd1);
    check_gap("respawn");
    cyc(1);
    check("spawn_off", 32'(spawn), 32'd0);
    // Tick held two cycles moves twice
    tick = 1'b1;
    cyc(2);
    tick = 1'b0;
    check("x_hold2", 32'(pipe_x), 32'd682);

    // Collision priority over a same-cycle tick
    collided = 1'b1;
    tick = 1'b1;
    cyc(1);
    collided = 1'b0;
    tick = 1'b0;
    check("hit_state", 32'(state), 32'd3);
    check("hit_x", 32'(pipe_x), 32'd682);
    check("hit_score", 32'(score), 32'd1);
    check("hit_flash0", 32'(flash), 32'd0);
    pulse_tick();
    check("flash_t1", 32'(flash), 32'd1);
    pulse_start();
    check("hit_start_ign", 32'(state), 32'd3);
    pulse_tick();
    check("flash_t2", 32'(flash), 32'd0);
    pulse_tick();
    check("flash_t3", 32'(flash), 32'd1);
    check("hit_t3_state", 32'(state), 32'd3);
    pulse_tick();
    check("over_state", 32'(state), 32'd4);
    check("over_flash", 32'(flash), 32'd0);
    check("over_go", 32'(game_over), 32'd1);
    check("over_hi", 32'(hi_score), 32'd1);
    check("over_score", 32'(score), 32'd1);
    check("over_x", 32'(pipe_x), 32'd682);
    pulse_tick();
    check("over_tick_ign", 32'(state), 32'd4);

    // Restart, second game ends with score 0
    pulse_start();
    check("rs_state", 32'(state), 32'd1);
    check("rs_score", 32'(score), 32'd0);
    check("rs_x", 32'(pipe_x), 32'd690);
    check("rs_go", 32'(game_over), 32'd0);
    check("rs_hi", 32'(hi_score), 32'd1);
    ticks(3);
    check("rs_run", 32'(state), 32'd2);
    collided = 1'b1;
    cyc(1);
    collided = 1'b0;
    check("g2_hit", 32'(state), 32'd3);
    ticks(4);
    check("g2_over", 32'(state), 32'd4);
    check("g2_score", 32'(score), 32'd0);
    check("g2_hi", 32'(hi_score), 32'd1);

    // Reset in the middle of HIT
    pulse_start();
    ticks(3);
    collided = 1'b1;
    cyc(1);
    collided = 1'b0;
    pulse_tick();
    check("g3_hit", 32'(state), 32'd3);
    check("g3_flash", 32'(flash), 32'd1);
    reset = 1'b1;
    cyc(1);
    check_reset_vals("midrst");
    reset = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
